// File: rtl/mem_to_banks_sparse.sv
// Splits a wide memory port across NumBanks banks, issuing only banks with live byte-enables.
// Responses are reassembled in acceptance order, and all-zero requests are answered locally.

module mem_to_banks_sparse_fifo #(
    parameter int W            = 8,
    parameter int DEPTH        = 2,
    parameter bit FALL_THROUGH = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PW-1:0]           rd_q, wr_q;
    logic [CW-1:0]           cnt_q;
    logic                    empty, bypass, do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    // An entry arriving at an empty fall-through FIFO is visible in the same cycle.
    assign bypass  = FALL_THROUGH && empty && push_i;
    assign valid_o = !empty || bypass;
    assign data_o  = bypass ? data_i : mem_q[rd_q];
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && !(bypass && pop_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= inc(wr_q);
            if (do_pop)  rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

module mem_to_banks_sparse_lane #(
    parameter int RW        = 8,
    parameter int DW        = 8,
    parameter int FifoDepth = 2,
    parameter int MaxTrans  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_push_i,
    input  logic [RW-1:0] req_data_i,
    output logic          req_full_o,
    output logic          bank_req_o,
    input  logic          bank_gnt_i,
    output logic [RW-1:0] bank_data_o,
    input  logic          bank_rvalid_i,
    input  logic [DW-1:0] bank_rdata_i,
    input  logic          resp_pop_i,
    output logic          resp_valid_o,
    output logic [DW-1:0] resp_data_o
);
    logic resp_full;

    mem_to_banks_sparse_fifo #(.W(RW), .DEPTH(FifoDepth), .FALL_THROUGH(1'b1)) u_req (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (req_push_i),
        .data_i  (req_data_i),
        .pop_i   (bank_req_o && bank_gnt_i),
        .full_o  (req_full_o),
        .valid_o (bank_req_o),
        .data_o  (bank_data_o)
    );

    mem_to_banks_sparse_fifo #(.W(DW), .DEPTH(MaxTrans), .FALL_THROUGH(1'b1)) u_resp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bank_rvalid_i),
        .data_i  (bank_rdata_i),
        .pop_i   (resp_pop_i),
        .full_o  (resp_full),
        .valid_o (resp_valid_o),
        .data_o  (resp_data_o)
    );

    // Outstanding count bounds bank responses, so a push into a full FIFO means a misbehaving bank.
    a_resp_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(bank_rvalid_i && resp_full && !resp_pop_i));
endmodule

module mem_to_banks_sparse #(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 64,
    parameter int NumBanks   = 4,
    parameter int MaxTrans   = 4,
    parameter int FifoDepth  = 2,
    parameter int WUserWidth = 1,
    parameter int RUserWidth = 1,
    parameter bit SkipReads  = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    output logic                           gnt_o,
    input  logic [AddrWidth-1:0]           addr_i,
    input  logic [DataWidth-1:0]           wdata_i,
    input  logic [DataWidth/8-1:0]         strb_i,
    input  logic [WUserWidth-1:0]          wuser_i,
    input  logic                           we_i,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [DataWidth-1:0]           rdata_o,
    output logic [NumBanks*RUserWidth-1:0] ruser_o,
    output logic [NumBanks-1:0]            bank_req_o,
    input  logic [NumBanks-1:0]            bank_gnt_i,
    output logic [NumBanks*AddrWidth-1:0]  bank_addr_o,
    output logic [DataWidth-1:0]           bank_wdata_o,
    output logic [DataWidth/8-1:0]         bank_strb_o,
    output logic [NumBanks*WUserWidth-1:0] bank_wuser_o,
    output logic [NumBanks-1:0]            bank_we_o,
    input  logic [NumBanks-1:0]            bank_rvalid_i,
    input  logic [DataWidth-1:0]           bank_rdata_i,
    input  logic [NumBanks*RUserWidth-1:0] bank_ruser_i
);
    localparam int BW = DataWidth / NumBanks;
    localparam int BS = BW / 8;
    localparam int SW = DataWidth / 8;
    localparam int RW = AddrWidth + BW + BS + WUserWidth + 1;
    localparam int DW = BW + RUserWidth;
    localparam int CW = $clog2(MaxTrans + 1);

    if ((DataWidth % NumBanks) != 0 || (BW % 8) != 0 || MaxTrans < 1 || FifoDepth < 1 ||
        (DataWidth & (DataWidth - 1)) != 0) begin : g_bad_params
        $error("mem_to_banks_sparse: illegal parameter set");
    end

    logic [NumBanks-1:0]         active, req_full, head_mask, resp_valid, resp_pop;
    logic [NumBanks-1:0][RW-1:0] req_data, bank_data;
    logic [NumBanks-1:0][DW-1:0] resp_data;
    logic                        mask_valid, mask_full, accept, rsp_fire;
    logic [CW-1:0]               cnt_q;
    logic [AddrWidth-1:0]        base_addr;

    assign base_addr = addr_i & ~AddrWidth'(SW - 1);

    // Only FIFOs that will actually take a slice need room; idle banks never stall the request.
    assign gnt_o    = (cnt_q < CW'(MaxTrans)) && !mask_full && !(|(req_full & active));
    assign accept   = req_i && gnt_o;
    assign rvalid_o = mask_valid && (&(resp_valid | ~head_mask));
    assign rsp_fire = rvalid_o && rready_i;
    assign resp_pop = {NumBanks{rsp_fire}} & head_mask;

    for (genvar i = 0; i < NumBanks; i++) begin : g_bank
        assign active[i]   = (we_i || SkipReads) ? |strb_i[i*BS +: BS] : 1'b1;
        assign req_data[i] = {base_addr + AddrWidth'(i * BS), wdata_i[i*BW +: BW],
                              strb_i[i*BS +: BS], wuser_i, we_i};
        assign {bank_addr_o[i*AddrWidth +: AddrWidth], bank_wdata_o[i*BW +: BW],
                bank_strb_o[i*BS +: BS], bank_wuser_o[i*WUserWidth +: WUserWidth],
                bank_we_o[i]} = bank_data[i];

        mem_to_banks_sparse_lane #(
            .RW(RW), .DW(DW), .FifoDepth(FifoDepth), .MaxTrans(MaxTrans)
        ) u_lane (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .req_push_i    (accept && active[i]),
            .req_data_i    (req_data[i]),
            .req_full_o    (req_full[i]),
            .bank_req_o    (bank_req_o[i]),
            .bank_gnt_i    (bank_gnt_i[i]),
            .bank_data_o   (bank_data[i]),
            .bank_rvalid_i (bank_rvalid_i[i]),
            .bank_rdata_i  ({bank_rdata_i[i*BW +: BW], bank_ruser_i[i*RUserWidth +: RUserWidth]}),
            .resp_pop_i    (resp_pop[i]),
            .resp_valid_o  (resp_valid[i]),
            .resp_data_o   (resp_data[i])
        );

        assign rdata_o[i*BW +: BW] = (rvalid_o && head_mask[i]) ? resp_data[i][RUserWidth +: BW] : '0;
        assign ruser_o[i*RUserWidth +: RUserWidth] =
            (rvalid_o && head_mask[i]) ? resp_data[i][RUserWidth-1:0] : '0;
    end

    mem_to_banks_sparse_fifo #(.W(NumBanks), .DEPTH(MaxTrans), .FALL_THROUGH(1'b0)) u_mask (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (active),
        .pop_i   (rsp_fire),
        .full_o  (mask_full),
        .valid_o (mask_valid),
        .data_o  (head_mask)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                     cnt_q <= '0;
        else if (accept && !rsp_fire)  cnt_q <= cnt_q + 1'b1;
        else if (!accept && rsp_fire)  cnt_q <= cnt_q - 1'b1;
    end

    a_rvalid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        rvalid_o && !rready_i |=> rvalid_o && $stable(rdata_o) && $stable(ruser_o));
endmodule

// File: tb/tb_mem_to_banks_sparse.sv
// Directed bench: two splitters (SkipReads 0 and 1) driven by simple one-cycle-latency bank models.
module tb_mem_to_banks_sparse;
    localparam int AW = 32, DW = 64, NB = 4, SW = DW / 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic          req, req_b, we, rready;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [0:0]    wuser;
    logic [NB-1:0] bgnt;

    logic           a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0]  a_rdata, a_bwdata, a_brd, b_rdata, b_bwdata, b_brd;
    logic [NB-1:0]  a_ruser, a_breq, a_bwuser, a_bwe, a_brv, b_ruser, b_breq, b_bwuser, b_bwe, b_brv;
    logic [NB*AW-1:0] a_baddr, b_baddr;
    logic [SW-1:0]  a_bstrb, b_bstrb;
    logic [NB-1:0]  bruser;
    assign bruser = '1;

    mem_to_banks_sparse #(.SkipReads(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(a_gnt), .addr_i(addr), .wdata_i(wdata),
        .strb_i(strb), .wuser_i(wuser), .we_i(we), .rvalid_o(a_rvalid), .rready_i(rready),
        .rdata_o(a_rdata), .ruser_o(a_ruser), .bank_req_o(a_breq), .bank_gnt_i(bgnt),
        .bank_addr_o(a_baddr), .bank_wdata_o(a_bwdata), .bank_strb_o(a_bstrb),
        .bank_wuser_o(a_bwuser), .bank_we_o(a_bwe), .bank_rvalid_i(a_brv),
        .bank_rdata_i(a_brd), .bank_ruser_i(bruser));

    mem_to_banks_sparse #(.SkipReads(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(b_gnt), .addr_i(addr), .wdata_i(wdata),
        .strb_i(strb), .wuser_i(wuser), .we_i(we), .rvalid_o(b_rvalid), .rready_i(rready),
        .rdata_o(b_rdata), .ruser_o(b_ruser), .bank_req_o(b_breq), .bank_gnt_i(bgnt),
        .bank_addr_o(b_baddr), .bank_wdata_o(b_bwdata), .bank_strb_o(b_bstrb),
        .bank_wuser_o(b_bwuser), .bank_we_o(b_bwe), .bank_rvalid_i(b_brv),
        .bank_rdata_i(b_brd), .bank_ruser_i(bruser));

    // Banks answer one cycle after a grant with the bitwise inverse of the low address half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_brv <= '0; a_brd <= '0; b_brv <= '0; b_brd <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                a_brv[i]         <= a_breq[i] & bgnt[i];
                a_brd[i*16 +: 16] <= ~a_baddr[i*AW +: 16];
                b_brv[i]         <= b_breq[i] & bgnt[i];
                b_brd[i*16 +: 16] <= ~b_baddr[i*AW +: 16];
            end
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp5 [5];

    initial begin
        exp5 = '{64'hBFF9_BFFB_BFFD_BFFF, 64'hBFF1_BFF3_BFF5_BFF7, 64'hBFE9_BFEB_BFED_BFEF,
                 64'hBFE1_BFE3_BFE5_BFE7, 64'hBFD9_BFDB_BFDD_BFDF};
        req = 0; req_b = 0; we = 0; rready = 1; addr = '0; wdata = '0; strb = '0; wuser = '0;
        bgnt = '1;

        @(negedge clk);
        chk("rst_gnt", a_gnt, 1); chk("rst_breq", a_breq, 0);
        chk("rst_rvalid", a_rvalid, 0); chk("rst_rdata", a_rdata, 0);

        // full write, unaligned address
        step(); rst = 0; req = 1; we = 1; addr = 32'h1003; strb = 8'hFF;
        wdata = 64'h1122_3344_5566_7788;
        @(negedge clk);
        chk("w_gnt", a_gnt, 1); chk("w_breq", a_breq, 4'hF);
        chk("w_baddr", a_baddr, {32'h1006, 32'h1004, 32'h1002, 32'h1000});
        chk("w_bwdata", a_bwdata, 64'h1122_3344_5566_7788); chk("w_bwe", a_bwe, 4'hF);
        chk("w_rvalid_accept", a_rvalid, 0);
        step(); req = 0;
        @(negedge clk); chk("w_rvalid", a_rvalid, 1); chk("w_ruser", a_ruser, 4'hF);
        step();
        @(negedge clk); chk("w_idle", a_rvalid, 0);

        // write touching bank 1 only
        step(); req = 1; addr = 32'h2000; strb = 8'h0C;
        @(negedge clk);
        chk("b1_gnt", a_gnt, 1); chk("b1_breq", a_breq, 4'b0010); chk("b1_bstrb", a_bstrb, 8'h0C);
        step(); req = 0;
        @(negedge clk);
        chk("b1_rvalid", a_rvalid, 1); chk("b1_rdata", a_rdata, 64'h0000_0000_DFFD_0000);
        chk("b1_ruser", a_ruser, 4'b0010);

        // all-zero write answered locally
        step(); req = 1; addr = 32'h3000; strb = 8'h00;
        @(negedge clk);
        chk("z_gnt", a_gnt, 1); chk("z_breq", a_breq, 0); chk("z_rvalid_accept", a_rvalid, 0);
        step(); req = 0;
        @(negedge clk); chk("z_rvalid", a_rvalid, 1); chk("z_rdata", a_rdata, 0);
        step();
        @(negedge clk); chk("z_idle", a_rvalid, 0);

        // partial read on both DUTs
        step(); req = 1; req_b = 1; we = 0; addr = 32'h2000; strb = 8'h03;
        @(negedge clk);
        chk("rd_breq_a", a_breq, 4'hF); chk("rd_breq_b", b_breq, 4'b0001);
        step(); req = 0; req_b = 0;
        @(negedge clk);
        chk("rd_rvalid_a", a_rvalid, 1); chk("rd_rdata_a", a_rdata, 64'hDFF9_DFFB_DFFD_DFFF);
        chk("rd_rvalid_b", b_rvalid, 1); chk("rd_rdata_b", b_rdata, 64'h0000_0000_0000_DFFF);

        // outstanding limit with backpressure
        strb = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            step(); rready = 0; req = 1; addr = 32'h4000 + 32'(8 * k);
            @(negedge clk); chk($sformatf("mt_gnt%0d", k), a_gnt, 1);
        end
        step(); addr = 32'h4020;
        @(negedge clk);
        chk("mt_gnt_full", a_gnt, 0); chk("mt_hold_rvalid", a_rvalid, 1);
        chk("mt_hold_rdata", a_rdata, exp5[0]);
        step(); rready = 1;
        @(negedge clk);
        chk("mt_gnt_pop", a_gnt, 0); chk("mt_rdata0", a_rdata, exp5[0]);
        step();
        @(negedge clk); chk("mt_gnt_5th", a_gnt, 1); chk("mt_rdata1", a_rdata, exp5[1]);
        step(); req = 0;
        @(negedge clk); chk("mt_cnt_same", dut_a.cnt_q, 3); chk("mt_rdata2", a_rdata, exp5[2]);
        step();
        @(negedge clk); chk("mt_rdata3", a_rdata, exp5[3]);
        step();
        @(negedge clk); chk("mt_rdata4", a_rdata, exp5[4]); chk("mt_rvalid4", a_rvalid, 1);
        step();
        @(negedge clk); chk("mt_drained", a_rvalid, 0); chk("mt_cnt_zero", dut_a.cnt_q, 0);

        // bank 2 stalls its grant
        step(); req = 1; addr = 32'h5000; bgnt = 4'b1011;
        @(negedge clk); chk("st_gnt", a_gnt, 1); chk("st_breq", a_breq, 4'hF);
        step(); req = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk($sformatf("st_rvalid%0d", j), a_rvalid, 0);
            chk($sformatf("st_breq%0d", j), a_breq, 4'b0100);
            chk($sformatf("st_baddr%0d", j), a_baddr[95:64], 32'h5004);
            step();
        end
        bgnt = 4'hF;
        @(negedge clk); chk("st_rel_rvalid", a_rvalid, 0);
        step();
        @(negedge clk);
        chk("st_rvalid", a_rvalid, 1); chk("st_rdata", a_rdata, 64'hAFF9_AFFB_AFFD_AFFF);

        // reset in the middle of traffic
        step(); rready = 0; req = 1; addr = 32'h6000;
        @(negedge clk); chk("mr_gnt0", a_gnt, 1);
        step(); addr = 32'h6008; bgnt = 4'b1011;
        @(negedge clk); chk("mr_rvalid_pre", a_rvalid, 1); chk("mr_gnt1", a_gnt, 1);
        step(); req = 0;
        @(negedge clk); chk("mr_breq_pre", a_breq, 4'b0100);
        step(); rst = 1;
        #1;
        chk("mr_breq_rst", a_breq, 0); chk("mr_rvalid_rst", a_rvalid, 0);
        chk("mr_rdata_rst", a_rdata, 0);
        step(); rst = 0; bgnt = 4'hF; rready = 1;
        @(negedge clk);
        chk("mr_gnt_post", a_gnt, 1); chk("mr_breq_post", a_breq, 0);
        chk("mr_rvalid_post", a_rvalid, 0);

        // traffic resumes cleanly after reset
        step(); req = 1; addr = 32'h2000;
        @(negedge clk); chk("rc_gnt", a_gnt, 1);
        step(); req = 0;
        @(negedge clk);
        chk("rc_rvalid", a_rvalid, 1); chk("rc_rdata", a_rdata, 64'hDFF9_DFFB_DFFD_DFFF);
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
